// File: rtl/updown_counter_mod_pkg.sv
// counter_pkg: shared types and helpers for the up/down counter slice.
//   cnt_mode_e   - end-of-range behaviour (wrap or saturate)
//   pre_width()  - prescaler register width, max($clog2(PRESCALE),1)
//   clamp_load() - limits a load value to MODULUS-1. The compare is done
//                  wider than WIDTH so that MODULUS == 2**WIDTH is handled.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Default prescaler width. Instances size their own prescaler with
    // pre_width(PRESCALE).
    localparam int PRE_W = 1;

    function automatic int pre_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [32:0] clamp_load(input logic [32:0] val,
                                               input logic [32:0] modulus);
        return (val >= modulus) ? (modulus - 33'd1) : val;
    endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// updown_counter_mod_if: control/status bundle of the up/down counter.
//   master drives: clr, load, load_val, en, up, ovf_clr
//   slave drives:  count, tc, ovf_sticky
interface updown_counter_mod_if #(
    parameter int WIDTH = 5
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf_sticky;

    modport master (
        output clr, load, load_val, en, up, ovf_clr,
        input  count, tc, ovf_sticky
    );

    modport slave (
        input  clr, load, load_val, en, up, ovf_clr,
        output count, tc, ovf_sticky
    );
endinterface

// File: rtl/updown_counter_mod_prescale.sv
// prescale_tick: divides enabled cycles by PRESCALE.
//   clk, resetn  - clock, asynchronous active-low reset
//   en           - advance the prescaler this cycle
//   sync_clr     - return the phase to 0 (parent clear/load)
//   step         - combinational, high on the enabled cycle that completes a period
module prescale_tick
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
)(
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic sync_clr,
    output logic step
);

    localparam int                  PW   = pre_width(PRESCALE);
    localparam logic [PW-1:0]       LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // With PRESCALE == 1 the phase stays 0 and every enabled cycle steps.
    assign step = en && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = step ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo up/down counter with prescaled stepping,
// wrap or saturate at the range ends, and a terminal-count pulse plus a
// sticky overflow flag. All outputs are registered.
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset
//   ctrl    - updown_counter_mod_if slave: clr/load/load_val/en/up/ovf_clr in,
//             count/tc/ovf_sticky out
// Priority on each edge is clr, then load, then a prescaled step.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int MODULUS     = (1 << WIDTH),
    parameter int SATURATE    = 0,
    parameter int PRESCALE    = 1,
    parameter int RESET_VALUE = 0
)(
    input  logic                 clk,
    input  logic                 resetn,
    updown_counter_mod_if.slave  ctrl
);

    localparam cnt_mode_e        MODE    = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be >= 2");
    end
    if (MODULUS > (1 << WIDTH)) begin : g_bad_mod_hi
        $error("updown_counter_mod: MODULUS exceeds 2**WIDTH");
    end
    if (MODULUS < 2) begin : g_bad_mod_lo
        $error("updown_counter_mod: MODULUS must be >= 2");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_rst
        $error("updown_counter_mod: RESET_VALUE must be < MODULUS");
    end
    if (PRESCALE < 1) begin : g_bad_pre
        $error("updown_counter_mod: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk      (clk),
        .resetn   (resetn),
        .en       (ctrl.en),
        .sync_clr (ctrl.clr | ctrl.load),
        .step     (step)
    );

    // A boundary step (wrap, or a hold at the end in saturate mode) raises tc
    // for the following cycle.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (ctrl.clr) begin
            count_d = RST_VAL;
        end else if (ctrl.load) begin
            count_d = WIDTH'(clamp_load(33'(ctrl.load_val), 33'(MODULUS)));
        end else if (step) begin
            if (ctrl.up) begin
                if (count_q == MAX_VAL) begin
                    tc_d    = 1'b1;
                    count_d = (MODE == CNT_SAT) ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (MODE == CNT_SAT) ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // A new overflow beats a simultaneous ovf_clr.
    always_comb begin
        ovf_d = ovf_q;
        if (tc_d) begin
            ovf_d = 1'b1;
        end else if (ctrl.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ctrl.count      = count_q;
    assign ctrl.tc         = tc_q;
    assign ctrl.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: drives four differently configured counters with
// the same stimulus and compares each against a behavioural model. The
// expected outputs for an edge are queued when the stimulus is applied and
// popped once the edge has happened.
//   dut0: defaults            dut1: MODULUS=24
//   dut2: SATURATE=1          dut3: PRESCALE=3
module tb_updown_counter_mod;

    localparam int N = 4;
    localparam int MODS [N] = '{32, 24, 32, 32};
    localparam int SATS [N] = '{0, 0, 1, 0};
    localparam int PRES [N] = '{1, 1, 1, 3};

    typedef struct {
        int cnt;
        int pre;
        bit tc;
        bit ovf;
    } model_t;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       clr      = 1'b0;
    logic       load     = 1'b0;
    logic [4:0] load_val = '0;
    logic       en       = 1'b0;
    logic       up       = 1'b0;
    logic       ovf_clr  = 1'b0;

    logic [6:0] actual [N];
    model_t     mdl [N];
    logic [N*7-1:0] expq [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        updown_counter_mod_if #(.WIDTH(5)) ifc ();

        assign ifc.clr      = clr;
        assign ifc.load     = load;
        assign ifc.load_val = load_val;
        assign ifc.en       = en;
        assign ifc.up       = up;
        assign ifc.ovf_clr  = ovf_clr;

        updown_counter_mod #(
            .WIDTH       (5),
            .MODULUS     (MODS[g]),
            .SATURATE    (SATS[g]),
            .PRESCALE    (PRES[g]),
            .RESET_VALUE (0)
        ) dut (
            .clk    (clk),
            .resetn (resetn),
            .ctrl   (ifc)
        );

        assign actual[g] = {ifc.ovf_sticky, ifc.tc, ifc.count};
    end

    // Reference behaviour of one edge for configuration k.
    function automatic model_t model_next(input model_t s, input int k);
        model_t n;
        int     modu;
        n    = s;
        modu = MODS[k];
        n.tc = 1'b0;
        if (clr) begin
            n.cnt = 0;
            n.pre = 0;
        end else if (load) begin
            n.cnt = (int'(load_val) > modu - 1) ? modu - 1 : int'(load_val);
            n.pre = 0;
        end else if (en) begin
            if (s.pre == PRES[k] - 1) begin
                n.pre = 0;
                if (up) begin
                    if (s.cnt == modu - 1) begin
                        n.tc  = 1'b1;
                        n.cnt = (SATS[k] != 0) ? s.cnt : 0;
                    end else begin
                        n.cnt = s.cnt + 1;
                    end
                end else begin
                    if (s.cnt == 0) begin
                        n.tc  = 1'b1;
                        n.cnt = (SATS[k] != 0) ? 0 : modu - 1;
                    end else begin
                        n.cnt = s.cnt - 1;
                    end
                end
            end else begin
                n.pre = s.pre + 1;
            end
        end
        if (n.tc) n.ovf = 1'b1;
        else if (ovf_clr) n.ovf = 1'b0;
        return n;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < N; k++) begin
            mdl[k].cnt = 0;
            mdl[k].pre = 0;
            mdl[k].tc  = 1'b0;
            mdl[k].ovf = 1'b0;
        end
    endtask

    // Queue the expected result of the coming edge, then let it happen.
    task automatic applyStimulus();
        logic [N*7-1:0] e;
        for (int k = 0; k < N; k++) begin
            if (resetn) mdl[k] = model_next(mdl[k], k);
            e[k*7 +: 7] = {mdl[k].ovf, mdl[k].tc, 5'(mdl[k].cnt)};
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] zero;
        zero = '0;
        resetn = 1'b0;
        set_idle();
        reset_model();
        #22;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (actual[k] !== zero) begin
                errors++;
                $display("[TB] FAIL reset dut%0d got %h want %h", k, actual[k], zero);
            end
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_up();
        logic [N*7-1:0] e;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL count_up dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_count_down();
        logic [N*7-1:0] e;
        for (int i = 0; i < 32; i++) begin
            set_idle();
            if (i == 0) ovf_clr = 1'b1;
            else if (i == 1) clr = 1'b1;
            else begin en = 1'b1; up = 1'b0; end
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL count_down dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_load_clamp();
        logic [N*7-1:0] e;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            if (i == 0) begin load = 1'b1; load_val = 5'd30; en = 1'b1; end
            if (i == 2) begin load = 1'b1; load_val = 5'd31; end
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL load_clamp dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_saturate();
        logic [N*7-1:0] e;
        for (int i = 0; i < 10; i++) begin
            set_idle();
            if (i == 0) ovf_clr = 1'b1;
            else if (i == 1) begin load = 1'b1; load_val = 5'd30; end
            else begin
                en = 1'b1; up = 1'b1;
                if (i == 5) ovf_clr = 1'b1;
            end
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL saturate dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_prescale();
        logic [N*7-1:0] e;
        for (int i = 0; i < 18; i++) begin
            set_idle();
            up = 1'b1;
            if (i == 0) clr = 1'b1;
            else if (i == 6 || i == 7) en = 1'b0;
            else if (i == 11) begin load = 1'b1; load_val = 5'd10; en = 1'b1; end
            else en = 1'b1;
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL prescale dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_simultaneous();
        logic [N*7-1:0] e;
        for (int i = 0; i < 4; i++) begin
            set_idle();
            up = 1'b1;
            if (i == 0) begin clr = 1'b1; load = 1'b1; load_val = 5'd17; en = 1'b1; end
            if (i == 1) begin load = 1'b1; load_val = 5'd9; en = 1'b1; end
            if (i == 2) begin load = 1'b1; load_val = 5'd31; en = 1'b1; end
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL simultaneous dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        logic [N*7-1:0] e;
        logic [6:0]     zero;
        zero = '0;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin
                #3;
                resetn = 1'b0;
                reset_model();
                #1;
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (actual[k] !== zero) begin
                        errors++;
                        $display("[TB] FAIL async_reset dut%0d got %h want %h", k, actual[k], zero);
                    end
                end
                resetn = 1'b1;
            end
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL async_run dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [N*7-1:0] e;
        for (int i = 0; i < 120; i++) begin
            clr      = ($urandom_range(0, 9) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 5'($urandom_range(0, 31));
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 3) != 0);
            ovf_clr  = !clr && !load && ($urandom_range(0, 5) == 0);
            applyStimulus();
            e = expq.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (actual[k] !== e[k*7 +: 7]) begin
                    errors++;
                    $display("[TB] FAIL random dut%0d cyc%0d got %h want %h", k, i, actual[k], e[k*7 +: 7]);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_saturate();
        test_prescale();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
